// File: rtl/drive_sequencer.sv
// Two-channel H-bridge drive sequencer: shared-counter PWM, line-following decode,
// collision back-off and tone-directed junction manoeuvres.
module drive_sequencer #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned PWM_HZ          = 80,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned FULL_PCT        = 40,
  parameter int unsigned HARD_PCT        = 30,
  parameter int unsigned VEER_PCT        = 25,
  parameter int unsigned MAX_PCT         = 80,
  parameter int unsigned BACKOFF_PERIODS = 20,
  parameter int unsigned TURN_PERIODS    = 48,
  parameter int unsigned BACK_PERIODS    = 96
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] dir_control_i,
  input  logic       col_detect_ni,
  input  logic       force_stop_i,
  input  logic       td_en_i,
  input  logic [2:0] td_dir_i,
  output logic       hb_en_a_o,
  output logic       hb_en_b_o,
  output logic       hb_in1_o,
  output logic       hb_in2_o,
  output logic       hb_in3_o,
  output logic       hb_in4_o,
  output logic [2:0] state_o,
  output logic       pwm_tick_o
);

  localparam int unsigned PERIOD   = CLK_HZ / PWM_HZ;
  localparam int unsigned FULL_EFF = (FULL_PCT > MAX_PCT) ? MAX_PCT : FULL_PCT;
  localparam int unsigned HARD_EFF = (HARD_PCT > MAX_PCT) ? MAX_PCT : HARD_PCT;
  localparam int unsigned VEER_EFF = (VEER_PCT > MAX_PCT) ? MAX_PCT : VEER_PCT;

  localparam logic [CNT_W-1:0] FULL_THR = CNT_W'(PERIOD * FULL_EFF / 100);
  localparam logic [CNT_W-1:0] HARD_THR = CNT_W'(PERIOD * HARD_EFF / 100);
  localparam logic [CNT_W-1:0] VEER_THR = CNT_W'(PERIOD * VEER_EFF / 100);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  localparam int unsigned TMR_MAX_A = (BACKOFF_PERIODS > TURN_PERIODS) ? BACKOFF_PERIODS
                                                                        : TURN_PERIODS;
  localparam int unsigned TMR_MAX   = (TMR_MAX_A > BACK_PERIODS) ? TMR_MAX_A : BACK_PERIODS;
  localparam int unsigned TMR_W     = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] BACKOFF_LAST = TMR_W'(BACKOFF_PERIODS - 1);
  localparam logic [TMR_W-1:0] TURN_LAST    = TMR_W'(TURN_PERIODS - 1);
  localparam logic [TMR_W-1:0] BACK_LAST    = TMR_W'(BACK_PERIODS - 1);

  typedef enum logic [2:0] {
    StForwards  = 3'd0,
    StCollision = 3'd1,
    StBackoff   = 3'd2,
    StJunction  = 3'd3,
    StTurn      = 3'd4,
    StHalt      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SpOff  = 2'd0,
    SpVeer = 2'd1,
    SpHard = 2'd2,
    SpFull = 2'd3
  } speed_e;

  typedef struct packed {
    speed_e a_spd;
    logic   a_rev;
    speed_e b_spd;
    logic   b_rev;
  } cmd_t;

  function automatic cmd_t mk_cmd(speed_e a_spd, logic a_rev, speed_e b_spd, logic b_rev);
    cmd_t c;
    c.a_spd = a_spd;
    c.a_rev = a_rev;
    c.b_spd = b_spd;
    c.b_rev = b_rev;
    return c;
  endfunction

  // Codes outside the table keep whatever the motors were last told to do.
  function automatic cmd_t decode_fwd(logic [3:0] code, cmd_t held);
    cmd_t c;
    case (code)
      4'b0000: c = mk_cmd(SpFull, 1'b0, SpFull, 1'b0);
      4'b0101: c = mk_cmd(SpVeer, 1'b0, SpFull, 1'b0);
      4'b0110: c = mk_cmd(SpVeer, 1'b1, SpFull, 1'b0);
      4'b0111: c = mk_cmd(SpFull, 1'b1, SpHard, 1'b0);
      4'b1001: c = mk_cmd(SpFull, 1'b0, SpVeer, 1'b0);
      4'b1010: c = mk_cmd(SpFull, 1'b0, SpVeer, 1'b1);
      4'b1011: c = mk_cmd(SpHard, 1'b0, SpFull, 1'b1);
      default: c = held;
    endcase
    return c;
  endfunction

  function automatic logic pwm_level(speed_e spd, logic [CNT_W-1:0] cnt);
    logic l;
    unique case (spd)
      SpVeer:  l = (cnt < VEER_THR);
      SpHard:  l = (cnt < HARD_THR);
      SpFull:  l = (cnt < FULL_THR);
      default: l = 1'b0;
    endcase
    return l;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TMR_W-1:0] turn_last_q, turn_last_d;
  logic             armed_q, armed_d;
  cmd_t             held_q, held_d;
  cmd_t             turn_q, turn_d;
  cmd_t             cmd_out;
  logic             en_a_q, en_a_d;
  logic             en_b_q, en_b_d;
  logic [3:0]       pins_q, pins_d;
  logic             pwm_tick;
  logic             collide;
  logic             a_on, b_on;

  assign pwm_tick = (cnt_q == CNT_LAST);
  assign collide  = ~col_detect_ni | force_stop_i;
  assign cnt_d    = pwm_tick ? '0 : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    turn_d      = turn_q;
    turn_last_d = turn_last_q;
    armed_d     = armed_q;
    unique case (state_q)
      StForwards: begin
        if (dir_control_i[3:2] != 2'b11) armed_d = 1'b1;
        if (collide) begin
          state_d = StCollision;
        end else if (dir_control_i[3:2] == 2'b11) begin
          if (armed_q) state_d = StJunction;
        end else begin
          held_d = decode_fwd(dir_control_i, held_q);
        end
      end
      StCollision: begin
        if (!collide) state_d = StBackoff;
      end
      StBackoff: begin
        if (collide) state_d = StCollision;
        else if (pwm_tick && timer_q == BACKOFF_LAST) state_d = StForwards;
      end
      StJunction: begin
        // A tone arriving together with a collision is dropped.
        if (collide) begin
          state_d = StCollision;
        end else if (td_en_i) begin
          case (td_dir_i)
            3'd0: begin
              state_d     = StTurn;
              turn_d      = mk_cmd(SpFull, 1'b0, SpFull, 1'b0);
              turn_last_d = TURN_LAST;
            end
            3'd1: begin
              state_d     = StTurn;
              turn_d      = mk_cmd(SpHard, 1'b1, SpHard, 1'b0);
              turn_last_d = TURN_LAST;
            end
            3'd2: begin
              state_d     = StTurn;
              turn_d      = mk_cmd(SpHard, 1'b0, SpHard, 1'b1);
              turn_last_d = TURN_LAST;
            end
            3'd3: begin
              state_d     = StTurn;
              turn_d      = mk_cmd(SpHard, 1'b1, SpHard, 1'b0);
              turn_last_d = BACK_LAST;
            end
            3'd4:    state_d = StHalt;
            default: state_d = StJunction;
          endcase
        end
      end
      StTurn: begin
        if (collide) begin
          state_d = StCollision;
        end else if (pwm_tick && timer_q == turn_last_q) begin
          state_d = StForwards;
          armed_d = 1'b0;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StForwards;
    endcase
  end

  always_comb begin
    if (state_d != state_q) timer_d = '0;
    else if (pwm_tick)      timer_d = timer_q + TMR_W'(1);
    else                    timer_d = timer_q;
  end

  // Outputs are derived from the state being entered so they change on the same edge.
  always_comb begin
    cmd_out = '0;
    unique case (state_d)
      StForwards: cmd_out = held_d;
      StBackoff:  cmd_out = mk_cmd(SpHard, 1'b1, SpHard, 1'b1);
      StTurn:     cmd_out = turn_d;
      default:    cmd_out = '0;
    endcase
    a_on   = (cmd_out.a_spd != SpOff);
    b_on   = (cmd_out.b_spd != SpOff);
    en_a_d = pwm_level(cmd_out.a_spd, cnt_q);
    en_b_d = pwm_level(cmd_out.b_spd, cnt_q);
    pins_d = {a_on & cmd_out.a_rev, a_on & ~cmd_out.a_rev,
              b_on & ~cmd_out.b_rev, b_on & cmd_out.b_rev};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StForwards;
      cnt_q       <= '0;
      timer_q     <= '0;
      turn_last_q <= '0;
      armed_q     <= 1'b1;
      held_q      <= '0;
      turn_q      <= '0;
      en_a_q      <= 1'b0;
      en_b_q      <= 1'b0;
      pins_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      turn_last_q <= turn_last_d;
      armed_q     <= armed_d;
      held_q      <= held_d;
      turn_q      <= turn_d;
      en_a_q      <= en_a_d;
      en_b_q      <= en_b_d;
      pins_q      <= pins_d;
    end
  end

  assign hb_en_a_o  = en_a_q;
  assign hb_en_b_o  = en_b_q;
  assign hb_in1_o   = pins_q[3];
  assign hb_in2_o   = pins_q[2];
  assign hb_in3_o   = pins_q[1];
  assign hb_in4_o   = pins_q[0];
  assign state_o    = state_q;
  assign pwm_tick_o = pwm_tick;

endmodule
